// File: rtl/ard_seq_sender.sv
// Queued code sender: a small FIFO feeds a HOLD/GAP strobe sequencer towards the Arduino link.
// Optional feature: define SEND_ACK_EN to end each hold early on a synchronised ard_ack.
module ard_seq_sender #(
  parameter int DATA_W      = 3,
  parameter int IN_W        = 4,
  parameter int MAX_CODE    = 6,
  parameter int HOLD_CYCLES = 1200000,
  parameter int GAP_CYCLES  = 120000,
  parameter int DEPTH       = 4
) (
  input  logic              hwclk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              strobe,
  input  logic              ard_ack,
  output logic              busy,
  output logic              done,
  output logic              clip_err,
  output logic              ack_timeout
);

  localparam int AW    = $clog2(DEPTH);
  localparam int MAX_T = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [AW:0]      PTR_ONE   = (AW + 1)'(1);
  localparam logic [IN_W-1:0]  MAX_IN    = IN_W'(MAX_CODE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GAP
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO: the extra pointer bit distinguishes full from empty.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic              in_clip;
  logic [DATA_W-1:0] wr_data;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign in_clip    = (in_data > MAX_IN);
  assign wr_data    = in_clip ? '0 : in_data[DATA_W-1:0];

  assign wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  // NOTE: storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge hwclk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              strobe_q, strobe_d;
  logic              done_q, done_d;
  logic              clip_q;
  logic              tmo_q, tmo_d;
  logic              hold_end, hold_timeout;

`ifdef SEND_ACK_EN
  logic [1:0] ack_sync_q;
  logic       ack_armed_q, ack_armed_d;
  logic       ack_s, ack_hit;

  assign ack_s        = ack_sync_q[1];
  // An ack still high from the previous symbol must drop before it counts.
  assign ack_armed_d  = (state_q == S_HOLD) ? (ack_armed_q || !ack_s) : 1'b0;
  assign ack_hit      = ack_s && ack_armed_q;
  assign hold_end     = ack_hit || (cnt_q == HOLD_LAST);
  assign hold_timeout = !ack_hit && (cnt_q == HOLD_LAST);

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q  <= '0;
      ack_armed_q <= 1'b0;
    end else begin
      ack_sync_q  <= {ack_sync_q[0], ard_ack};
      ack_armed_q <= ack_armed_d;
    end
  end
`else
  logic unused_ack;

  assign unused_ack   = ard_ack;
  assign hold_end     = (cnt_q == HOLD_LAST);
  assign hold_timeout = 1'b0;
`endif

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_ONE;
    data_out_d = data_out_q;
    strobe_d   = strobe_q;
    done_d     = 1'b0;
    tmo_d      = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_d    = S_HOLD;
          data_out_d = mem_q[rd_ptr_q[AW-1:0]];
          strobe_d   = 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_end) begin
          state_d    = S_GAP;
          cnt_d      = '0;
          data_out_d = '0;
          strobe_d   = 1'b0;
          tmo_d      = hold_timeout;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_d    = S_HOLD;
            data_out_d = mem_q[rd_ptr_q[AW-1:0]];
            strobe_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      data_out_q <= '0;
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
      clip_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      strobe_q   <= strobe_d;
      done_q     <= done_d;
      clip_q     <= push && in_clip;
      tmo_q      <= tmo_d;
    end
  end

  assign data_out    = data_out_q;
  assign strobe      = strobe_q;
  assign done        = done_q;
  assign clip_err    = clip_q;
  assign ack_timeout = tmo_q;
  assign busy        = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ard_seq_sender.sv
// Self-checking bench for ard_seq_sender: schedule-based reference model plus directed literal checks.
module tb_ard_seq_sender;

  localparam int HOLD   = 5;
  localparam int GAP    = 3;
  localparam int PERIOD = HOLD + GAP;
  localparam int DEPTH  = 4;
  localparam int MAXC   = 6;

  logic       hwclk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       ard_ack = 1'b0;
  logic       in_ready;
  logic [2:0] data_out;
  logic       strobe, busy, done, clip_err, ack_timeout;

  int checks = 0;
  int failures = 0;

  ard_seq_sender #(
    .DATA_W(3), .IN_W(4), .MAX_CODE(MAXC),
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .DEPTH(DEPTH)
  ) dut (
    .hwclk(hwclk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .strobe(strobe), .ard_ack(ard_ack),
    .busy(busy), .done(done), .clip_err(clip_err), .ack_timeout(ack_timeout)
  );

  always #5 hwclk = ~hwclk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: each accepted symbol gets a start edge; everything else follows from it.
  int t = 0;
  int last_start = -1000;
  int clip_edge = -1000;
  int m_val[$];
  int m_acc[$];
  int m_start[$];
  int done_seen = 0;

  function automatic void model_clear();
    m_val.delete();
    m_acc.delete();
    m_start.delete();
    last_start = -1000;
    clip_edge  = -1000;
  endfunction

  function automatic int occ_at(input int e);
    int n = 0;
    foreach (m_start[k]) if (m_acc[k] <= e && m_start[k] > e) n++;
    return n;
  endfunction

  initial begin : model_proc
    int tn;
    int st;
    forever begin
      @(posedge hwclk);
      tn = t + 1;
      if (!rst_n) begin
        model_clear();
      end else if (in_valid && occ_at(t) < DEPTH) begin
        st = (tn + 1 > last_start + PERIOD) ? tn + 1 : last_start + PERIOD;
        m_val.push_back((in_data > MAXC) ? 0 : int'(in_data[2:0]));
        m_acc.push_back(tn);
        m_start.push_back(st);
        last_start = st;
        if (in_data > MAXC) clip_edge = tn;
      end
      t = tn;
    end
  end

  initial forever begin
    @(negedge rst_n);
    model_clear();
  end

  initial begin : compare_proc
    int e_strobe, e_data, e_busy, e_done, e_ready, e_clip;
    int active, occ, st_now, end_now;
    forever begin
      @(negedge hwclk);
      e_strobe = 0; e_data = 0; active = 0; occ = 0; st_now = 0; end_now = 0;
      foreach (m_start[k]) begin
        if (m_start[k] <= t && t < m_start[k] + HOLD) begin
          e_strobe = 1;
          e_data   = m_val[k];
        end
        if (m_start[k] <= t && t < m_start[k] + PERIOD) active = 1;
        if (m_acc[k] <= t && m_start[k] > t) occ++;
        if (m_start[k] == t) st_now = 1;
        if (m_start[k] + PERIOD == t) end_now = 1;
      end
      e_done  = (end_now && !st_now) ? 1 : 0;
      e_busy  = (active || occ > 0) ? 1 : 0;
      e_ready = (occ < DEPTH) ? 1 : 0;
      e_clip  = (clip_edge == t) ? 1 : 0;
      check("cmp_strobe", int'(strobe), e_strobe);
      check("cmp_data_out", int'(data_out), e_data);
      check("cmp_done", int'(done), e_done);
      check("cmp_busy", int'(busy), e_busy);
      check("cmp_in_ready", int'(in_ready), e_ready);
      check("cmp_clip_err", int'(clip_err), e_clip);
`ifndef SEND_ACK_EN
      check("cmp_ack_timeout", int'(ack_timeout), 0);
`endif
      if (done) done_seen++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge hwclk);
      #1;
    end
  endtask

  // Presents one code and holds it until an edge with in_ready high takes it.
  task automatic send(input logic [3:0] v);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge hwclk);
      ok = in_ready;
      @(posedge hwclk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("send_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200 && busy; i++) step(1);
    check(name, int'(busy), 0);
    step(2);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int e;
    int d0;
    int highs;
    #1 rst_n = 1'b0;
    step(3);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_strobe", int'(strobe), 0);
    rst_n = 1'b1;
    step(2);

    // Single push: strobe for 5 cycles starting one edge after acceptance, done 8 edges later.
    d0 = done_seen;
    send(4'd5);
    e = t;
    check("model_first_start", m_start[0], e + 1);
    check("single_before_strobe", int'(strobe), 0);
    step(1);
    check("single_strobe_on", int'(strobe), 1);
    check("single_data", int'(data_out), 5);
    step(4);
    check("single_strobe_last", int'(strobe), 1);
    step(1);
    check("single_strobe_off", int'(strobe), 0);
    check("single_data_off", int'(data_out), 0);
    step(2);
    check("single_no_early_done", int'(done), 0);
    step(1);
    check("single_done", int'(done), 1);
    check("single_busy_low", int'(busy), 0);
    step(1);
    check("single_done_pulse", int'(done), 0);
    check("single_done_count", done_seen - d0, 1);
    step(2);

    // Fill and stall: 5 accepted back to back, the 6th waits for the second pop.
    d0 = done_seen;
    send(4'd1);
    e = t;
    send(4'd2);
    send(4'd3);
    send(4'd4);
    send(4'd6);
    check("fill_ready_low", int'(in_ready), 0);
    send(4'd2);
    check("stall_accept_edge", t - e, 10);
    step(7);
    check("fill_third_strobe", int'(strobe), 1);
    check("fill_third_data", int'(data_out), 3);
    wait_idle("fill_idle");
    check("fill_done_count", done_seen - d0, 1);

    // Clipping: out-of-range code sent as 0 with a full strobe.
    send(4'd9);
    check("clip_pulse", int'(clip_err), 1);
    step(1);
    check("clip_pulse_one", int'(clip_err), 0);
    check("clip_strobe", int'(strobe), 1);
    check("clip_data_zero", int'(data_out), 0);
    wait_idle("clip_idle");

    // Reset in the third HOLD cycle with two entries still queued.
    send(4'd1);
    send(4'd2);
    send(4'd3);
    step(1);
    check("rsthold_strobe_before", int'(strobe), 1);
    rst_n = 1'b0;
    #1;
    check("rsthold_strobe", int'(strobe), 0);
    check("rsthold_data", int'(data_out), 0);
    check("rsthold_busy", int'(busy), 0);
    check("rsthold_in_ready", int'(in_ready), 1);
    step(2);
    rst_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (strobe) highs++;
    end
    check("rsthold_nothing_sent", highs, 0);
    check("rsthold_busy_after", int'(busy), 0);

    // Push landing on the last GAP edge: IDLE with done first, HOLD one edge later.
    send(4'd4);
    e = t;
    step(8);
    send(4'd3);
    check("lastgap_accept_edge", t - e, 9);
    check("lastgap_done", int'(done), 1);
    check("lastgap_strobe_low", int'(strobe), 0);
    step(1);
    check("lastgap_strobe", int'(strobe), 1);
    check("lastgap_data", int'(data_out), 3);
    check("lastgap_done_clear", int'(done), 0);
    wait_idle("lastgap_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
